// File: rtl/ps2_key_ctrl_pkg.sv
// Shared definitions for the PS/2 key controller: decoder state encoding,
// protocol byte constants and the event record stored in the FIFO.
package ps2_key_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Keyboard status bytes: never key events. 00/FF are overrun/error reports.
  localparam logic [7:0] CODE_ERR0 = 8'h00;
  localparam logic [7:0] CODE_ERR1 = 8'hFF;
  localparam logic [7:0] CODE_BAT  = 8'hAA;
  localparam logic [7:0] CODE_ACK  = 8'hFA;
  localparam logic [7:0] CODE_RSND = 8'hFE;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } evt_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == CODE_ERR0) || (b == CODE_ERR1) || (b == CODE_BAT) ||
           (b == CODE_ACK)  || (b == CODE_RSND);
  endfunction

  function automatic logic is_err_code(input logic [7:0] b);
    return (b == CODE_ERR0) || (b == CODE_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO with a registered head: a push becomes visible one edge later,
// and a pop presents the following entry on the next cycle.
module ps2_evt_fifo
  import ps2_key_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [EVT_W-1:0] push_data_i,
  output logic             drop_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [EVT_W-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [EVT_W-1:0] mem_q [DEPTH];
  logic             valid_q, valid_d;
  logic [EVT_W-1:0] data_q, data_d;
  logic             full, pop, wr_en;

  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = valid_q && ready_i;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_comb begin
    rd_d    = rd_q + {{AW{1'b0}}, pop};
    wr_d    = wr_q + {{AW{1'b0}}, wr_en};
    // Head view is taken from post-pop, pre-push state: a fresh push shows
    // up one edge later, and a popped entry is never presented twice.
    valid_d = (wr_q != rd_d);
    data_d  = valid_d ? mem_q[rd_d[AW-1:0]] : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code set 2 decoder: folds E0/F0 prefixes into make/break events,
// suppresses typematic repeats, tracks the held key and queues events.
module ps2_key_ctrl
  import ps2_key_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_valid,
  input  logic [7:0] frame_data,
  input  logic       frame_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic [7:0] press_cnt,
  output logic       ovf,
  output logic       err,
  input  logic       sticky_clr
);

  logic [1:0] state_q, state_d;
  logic       held_valid_q, held_valid_d;
  logic       held_ext_q, held_ext_d;
  logic [7:0] held_code_q, held_code_d;
  logic [7:0] press_q, press_d;
  logic       ovf_q, ovf_d;
  logic       err_q, err_d;

  logic       emit, emit_ext, emit_rel, set_err, held_match, push, drop;
  evt_t       push_evt, head_evt;

  // Prefix decoder
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_rel = 1'b0;
    set_err  = 1'b0;
    if (frame_err) begin
      state_d = ST_IDLE;
      set_err = 1'b1;
    end else if (frame_valid) begin
      if (is_ignored(frame_data)) begin
        state_d = ST_IDLE;
        set_err = is_err_code(frame_data);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (frame_data == PFX_EXT)      state_d = ST_EXT;
            else if (frame_data == PFX_BRK) state_d = ST_BRK;
            else                            emit    = 1'b1;
          end
          ST_EXT: begin
            if (frame_data == PFX_BRK) begin
              state_d = ST_EXT_BRK;
            end else begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_BRK: begin
            emit     = 1'b1;
            emit_rel = 1'b1;
            state_d  = ST_IDLE;
          end
          default: begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
            state_d  = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Held-key tracking; a make equal to the held key is a typematic repeat.
  always_comb begin
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    press_d      = press_q;
    held_match   = held_valid_q && (held_ext_q == emit_ext) &&
                   (held_code_q == frame_data);
    push         = emit && (emit_rel || !held_match);
    if (emit && !emit_rel && !held_match) begin
      held_valid_d = 1'b1;
      held_ext_d   = emit_ext;
      held_code_d  = frame_data;
      press_d      = press_q + 8'd1;
    end
    if (emit && emit_rel && held_match) held_valid_d = 1'b0;
    ovf_d = drop    | (ovf_q & ~sticky_clr);
    err_d = set_err | (err_q & ~sticky_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      press_q      <= 8'h00;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      press_q      <= press_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

  assign push_evt = '{ext: emit_ext, rel: emit_rel, code: frame_data};

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_evt),
    .drop_o      (drop),
    .valid_o     (evt_valid),
    .ready_i     (evt_ready),
    .data_o      (head_evt)
  );

  assign evt_code    = head_evt.code;
  assign evt_ext     = head_evt.ext;
  assign evt_release = head_evt.rel;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign press_cnt   = press_q;
  assign ovf         = ovf_q;
  assign err         = err_q;

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port frame_valid  input  1  one-cycle pulse, new PS/2 byte from receiver.
REQ-005 SHALL have port frame_data  input  8  received byte, valid with frame_valid.
REQ-006 SHALL have port frame_err  input  1  one-cycle pulse, start/stop/parity failure.
REQ-007 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head when high with evt_valid.
REQ-009 SHALL have port evt_code  output  8  scan code of head event.
REQ-010 SHALL have port evt_ext  output  1  head event carried E0 prefix.
REQ-011 SHALL have port evt_release  output  1  head event is break (F0), else make.
REQ-012 SHALL have port held_valid / held_code  output  1/8  a key currently held, and its code.
REQ-013 SHALL have port press_cnt  output  8  count of accepted make events, wraps 255->0.
REQ-014 SHALL have port ovf / err  output  1/1  sticky FIFO overflow / sticky frame or protocol error.
REQ-015 SHALL have port sticky_clr  input  1  clears ovf and err.

Function
REQ-016 SHALL decode with FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-017 IDLE: E0->EXT, F0->BRK, other byte->emit make {ext=0} and stay IDLE.
REQ-018 EXT: F0->EXT_BRK, other->emit make {ext=1}, ->IDLE; BRK: any byte->emit break {ext=0}, ->IDLE; EXT_BRK: any byte->emit break {ext=1}, ->IDLE.
REQ-019 Bytes 0x00, 0xFF, 0xAA, 0xFA, 0xFE SHALL emit nothing and return FSM to IDLE; 0x00/0xFF additionally set err.
REQ-020 frame_err SHALL set err, return FSM to IDLE, and discard any pending prefix.
REQ-021 Make matching held_valid with same {ext,code} SHALL be treated as typematic repeat: not emitted, press_cnt unchanged.
REQ-022 Accepted make SHALL load held_code/held_ext, set held_valid, increment press_cnt, same cycle as FIFO push.
REQ-023 Break matching held {ext,code} SHALL clear held_valid; non-matching break leaves held state unchanged; all breaks are emitted.
REQ-024 Event push SHALL occur on the clock edge following frame_valid (latency 1); evt_valid rises on the edge after push.
REQ-025 Pop SHALL occur when evt_valid && evt_ready; outputs show next entry next cycle.
REQ-026 Full FIFO with push and no pop SHALL drop the event and set ovf; held/press_cnt still update.
REQ-027 Full FIFO with simultaneous push and pop SHALL accept the push (no ovf).
REQ-028 Empty FIFO: evt_valid=0, evt_code/ext/release hold last value; pop ignored.
REQ-029 Pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap-around, full/empty from MSB compare.
REQ-030 sticky_clr coincident with a setting event SHALL leave the flag set (set wins).
REQ-031 frame_valid and frame_err same cycle SHALL be handled as frame_err only.

Reset
REQ-032 On rst_n=0 at clk edge: FSM IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_ext=0, evt_release=0, held_valid=0, held_code=0, press_cnt=0, ovf=0, err=0.
REQ-033 Reset mid-sequence (e.g. after E0) SHALL discard the prefix; FIFO contents are lost.

Structure
REQ-034 Shared package SHALL hold FSM state encoding, prefix constants 0xE0/0xF0, ignored-code constants, event record width (10).
REQ-035 FIFO SHALL be one sub-module, ps2_evt_fifo (parameterised depth, width 10, ready/valid pop).

Verification
REQ-036 1C -> event {code=1C, ext=0, rel=0}, press_cnt=1, held_code=1C.
REQ-037 1C,1C,1C,F0,1C -> exactly two events: make 1C, break 1C; press_cnt=1; held_valid=0.
REQ-038 E0,F0,75 -> one event {code=75, ext=1, rel=1}; E0 then frame_err then 75 -> make {75, ext=0}, err=1.
REQ-039 evt_ready=0, 9 distinct makes, FIFO_DEPTH=8 -> 8 stored, ovf=1, press_cnt=9; drain order matches input.
REQ-040 Full FIFO, push and pop same cycle -> ovf stays 0, count stays 8; reset after E0 -> next 6B gives make {6B, ext=0}.
